// File: rtl/vector_read_port_pipe_if.sv
// Request/response bundle for the vector register read port.
// The slave side is the port itself; the master side is the requester and consumer.
interface vector_read_port_pipe_if #(
  parameter int I    = 20,
  parameter int L    = 8,
  parameter int NREG = 8,
  parameter int SW   = 4
);
  localparam int LW = (I > 1) ? $clog2(I) : 1;

  logic                             in_valid;
  logic                             in_ready;
  logic [SW-1:0]                    in_sel;
  logic                             in_bcast;
  logic [LW-1:0]                    in_lane;
  logic [I-1:0]                     in_mask;
  logic [NREG-1:0][I-1:0][L-1:0]    d;
  logic                             out_valid;
  logic                             out_ready;
  logic [I-1:0][L-1:0]              out_data;
  logic                             out_err;

  modport master (
    output in_valid, in_sel, in_bcast, in_lane, in_mask, d, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_sel, in_bcast, in_lane, in_mask, d, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/vector_read_port_pipe.sv
// Registered vector register read port: select, optional lane broadcast, lane mask,
// and a 2-entry skid output stage so a stalled consumer never loses a read.
module vector_read_port_pipe #(
  parameter int I    = 20,
  parameter int L    = 8,
  parameter int NREG = 8,
  parameter int BASE = 8,
  parameter int SW   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  vector_read_port_pipe_if.slave  bus
);

  localparam int LW   = (I > 1) ? $clog2(I) : 1;
  localparam int IDXW = (NREG > 1) ? $clog2(NREG) : 1;

  localparam logic [SW-1:0] BASE_S  = SW'(BASE);
  localparam logic [SW:0]   LO_S    = (SW+1)'(BASE);
  localparam logic [SW:0]   HI_S    = (SW+1)'(BASE + NREG);
  localparam logic [LW:0]   NLANE_S = (LW+1)'(I);

  generate
    if (BASE + NREG > 2**SW) begin : g_bad_sel_range
      $error("vector_read_port_pipe: BASE+NREG exceeds the in_sel range");
    end
  endgenerate

  typedef logic [I-1:0][L-1:0] vec_t;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  // Result of the request currently on the input side.
  logic [IDXW-1:0] idx;
  vec_t            v;
  vec_t            res_data;
  logic            res_err;

  always_comb begin
    idx      = IDXW'(bus.in_sel - BASE_S);
    v        = bus.d[idx];
    res_err  = ({1'b0, bus.in_sel} < LO_S) || ({1'b0, bus.in_sel} >= HI_S) ||
               (bus.in_bcast && ({1'b0, bus.in_lane} >= NLANE_S));
    res_data = v;
    if (bus.in_bcast) begin
      for (int j = 0; j < I; j++) res_data[j] = v[bus.in_lane];
    end
    for (int j = 0; j < I; j++) begin
      if (!bus.in_mask[j]) res_data[j] = '0;
    end
    if (res_err) res_data = '0;
  end

  state_t state_q, state_d;
  logic   out_valid_q, out_valid_d;
  logic   in_ready_q, in_ready_d;
  vec_t   out_data_q, out_data_d;
  logic   out_err_q, out_err_d;
  vec_t   skid_data_q, skid_data_d;
  logic   skid_err_q, skid_err_d;

  logic accept, xfer;
  assign accept = bus.in_valid & in_ready_q;
  assign xfer   = out_valid_q & bus.out_ready;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can infer a latch.
    state_d     = state_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    skid_data_d = skid_data_q;
    skid_err_d  = skid_err_q;
    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          out_data_d = res_data;
          out_err_d  = res_err;
          state_d    = ONE;
        end
      end
      ONE: begin
        if (accept && xfer) begin
          out_data_d = res_data;
          out_err_d  = res_err;
        end else if (accept) begin
          skid_data_d = res_data;
          skid_err_d  = res_err;
          state_d     = FULL;
        end else if (xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (xfer) begin
          out_data_d  = skid_data_q;
          out_err_d   = skid_err_q;
          skid_data_d = '0;
          skid_err_d  = 1'b0;
          state_d     = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    out_valid_d = (state_d != EMPTY);
    in_ready_d  = (state_d != FULL);
  end

  // NOTE: sequential state uses non-blocking assignments; the skid entry is reset as well
  // because it becomes the visible output after a FULL->ONE move.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      skid_data_q <= '0;
      skid_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      skid_data_q <= skid_data_d;
      skid_err_q  <= skid_err_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_vector_read_port_pipe.sv
// Directed bench for vector_read_port_pipe: d[k] lane j holds k*32+j, so every lane
// of every register is distinct and results can be written down by hand.
module tb_vector_read_port_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  vector_read_port_pipe_if #(.I(20), .L(8), .NREG(8), .SW(4)) bus ();

  vector_read_port_pipe #(.I(20), .L(8), .NREG(8), .BASE(8), .SW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [159:0] vec_of(input int k);
    logic [159:0] r;
    for (int j = 0; j < 20; j++) r[j*8 +: 8] = 8'(k*32 + j);
    return r;
  endfunction

  task automatic drive(input logic [3:0] sel, input logic bc, input logic [4:0] ln,
                       input logic [19:0] mk);
    bus.in_valid = 1'b1;
    bus.in_sel   = sel;
    bus.in_bcast = bc;
    bus.in_lane  = ln;
    bus.in_mask  = mk;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.out_data !== 160'd0) begin bad++; $display("FAIL reset_data got=%h want=0", bus.out_data); end
    total++; if (bus.out_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", bus.out_err); end
    rst = 1'b0;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", bus.in_ready); end
    @(negedge clk);
  endtask

  task automatic test_basic();
    drive(4'd8, 1'b0, 5'd0, 20'hFFFFF);
    @(negedge clk);
    idle();
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", bus.out_valid); end
    total++; if (bus.out_data !== vec_of(0)) begin bad++; $display("FAIL basic_data got=%h want=%h", bus.out_data, vec_of(0)); end
    total++; if (bus.out_err !== 1'b0) begin bad++; $display("FAIL basic_err got=%b want=0", bus.out_err); end
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL basic_drain got=%b want=0", bus.out_valid); end
    total++; if (bus.out_data !== vec_of(0)) begin bad++; $display("FAIL basic_hold got=%h want=%h", bus.out_data, vec_of(0)); end
  endtask

  task automatic test_bcast_mask();
    logic [159:0] exp;
    exp = {{16{8'h00}}, {4{8'hE3}}};
    drive(4'd15, 1'b1, 5'd3, 20'h0000F);
    @(negedge clk);
    idle();
    total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bcast_valid got=%b want=1", bus.out_valid); end
    total++; if (bus.out_data !== exp) begin bad++; $display("FAIL bcast_data got=%h want=%h", bus.out_data, exp); end
    total++; if (bus.out_err !== 1'b0) begin bad++; $display("FAIL bcast_err got=%b want=0", bus.out_err); end
    @(negedge clk);
  endtask

  task automatic test_errors();
    logic [3:0] sels  [3] = '{4'd7, 4'd0, 4'd8};
    logic       bcs   [3] = '{1'b0, 1'b0, 1'b1};
    logic [4:0] lanes [3] = '{5'd0, 5'd0, 5'd20};
    for (int t = 0; t < 3; t++) begin
      drive(sels[t], bcs[t], lanes[t], 20'hFFFFF);
      @(negedge clk);
      idle();
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL err%0d_valid got=%b want=1", t, bus.out_valid); end
      total++; if (bus.out_err !== 1'b1) begin bad++; $display("FAIL err%0d_flag got=%b want=1", t, bus.out_err); end
      total++; if (bus.out_data !== 160'd0) begin bad++; $display("FAIL err%0d_data got=%h want=0", t, bus.out_data); end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b0;
    drive(4'd9, 1'b0, 5'd0, 20'hFFFFF);
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready1 got=%b want=1", bus.in_ready); end
    total++; if (bus.out_data !== vec_of(1)) begin bad++; $display("FAIL b2b_first got=%h want=%h", bus.out_data, vec_of(1)); end
    total++; if (bus.out_err !== 1'b0) begin bad++; $display("FAIL b2b_err got=%b want=0", bus.out_err); end
    drive(4'd10, 1'b0, 5'd0, 20'hFFFFF);
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL b2b_full got=%b want=0", bus.in_ready); end
    drive(4'd11, 1'b0, 5'd0, 20'hFFFFF);
    @(negedge clk);
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL b2b_held got=%b want=0", bus.in_ready); end
    total++; if (bus.out_data !== vec_of(1) || bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL b2b_stable got=%h want=%h", bus.out_data, vec_of(1)); end
    bus.out_ready = 1'b1;
    @(negedge clk);
    total++; if (bus.out_data !== vec_of(2) || bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL b2b_second got=%h want=%h", bus.out_data, vec_of(2)); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_reopen got=%b want=1", bus.in_ready); end
    @(negedge clk);
    idle();
    total++; if (bus.out_data !== vec_of(3) || bus.out_valid !== 1'b1) begin
      bad++; $display("FAIL b2b_third got=%h want=%h", bus.out_data, vec_of(3)); end
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 17; i++) begin
      if (i < 16) drive(4'(8 + (i % 8)), 1'b0, 5'd0, 20'hFFFFF);
      else idle();
      if (i > 0) begin
        total++; if (bus.out_valid !== 1'b1 || bus.out_data !== vec_of((i-1) % 8)) begin
          bad++; $display("FAIL stream%0d got=%h want=%h", i, bus.out_data, vec_of((i-1) % 8)); end
      end
      if (i < 16) begin
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready%0d got=%b want=1", i, bus.in_ready); end
      end
      @(negedge clk);
    end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL stream_drain got=%b want=0", bus.out_valid); end
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1'b0;
    drive(4'd12, 1'b0, 5'd0, 20'hFFFFF);
    @(negedge clk);
    drive(4'd13, 1'b0, 5'd0, 20'hFFFFF);
    @(negedge clk);
    idle();
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL rmid_full got=%b want=0", bus.in_ready); end
    rst = 1'b1;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b want=0", bus.out_valid); end
    total++; if (bus.out_data !== 160'd0) begin bad++; $display("FAIL rmid_data got=%h want=0", bus.out_data); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b want=1", bus.in_ready); end
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    drive(4'd14, 1'b0, 5'd0, 20'hFFFFF);
    @(negedge clk);
    idle();
    total++; if (bus.out_valid !== 1'b1 || bus.out_data !== vec_of(6)) begin
      bad++; $display("FAIL rmid_next got=%h want=%h", bus.out_data, vec_of(6)); end
    @(negedge clk);
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rmid_noleak got=%b want=0", bus.out_valid); end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_sel    = '0;
    bus.in_bcast  = 1'b0;
    bus.in_lane   = '0;
    bus.in_mask   = '0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < 20; j++) bus.d[k][j] = 8'(k*32 + j);
    test_reset();
    test_basic();
    test_bcast_mask();
    test_errors();
    test_back_to_back();
    test_stream();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
